// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: word fetches into a small FIFO feeding decode.
// Optional per-entry illegal-encoding flag via `define PREFETCH_ILLEGAL_CHECK_EN.
module instr_prefetch #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr_data,
  output logic [AW-1:0] instr_pc,
`ifdef PREFETCH_ILLEGAL_CHECK_EN
  output logic          instr_illegal,
`endif
  output logic          instr_misaligned
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state;
  logic [AW-1:0]   fetch_pc, inflight_pc;
  logic            inflight;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic [31:0]     data_q [DEPTH];
  logic [AW-1:0]   pc_q   [DEPTH];
  logic [DEPTH-1:0] mis_q;
`ifdef PREFETCH_ILLEGAL_CHECK_EN
  logic [DEPTH-1:0] ill_q;
`endif

  logic            push, pop, misal;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [31:0]     wr_data;
  logic [AW-1:0]   wr_pc;

  assign misal = redirect_pc[1:0] != 2'b00;
  assign push  = inflight;
  assign pop   = instr_valid && instr_ready;

  // Reserve a slot for the in-flight word so a response can never overflow.
  assign imem_req  = rst && (state == RUN) && !redirect_valid &&
                     (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  assign instr_valid      = count != '0;
  assign instr_data       = instr_valid ? data_q[rd_ptr] : '0;
  assign instr_pc         = instr_valid ? pc_q[rd_ptr]   : '0;
  assign instr_misaligned = instr_valid && mis_q[rd_ptr];
`ifdef PREFETCH_ILLEGAL_CHECK_EN
  assign instr_illegal    = instr_valid && ill_q[rd_ptr];
`endif

  // A redirect flushes everything; a misaligned one leaves only its marker in slot 0.
  assign wr_en   = redirect_valid ? misal : push;
  assign wr_idx  = redirect_valid ? '0 : wr_ptr;
  assign wr_data = redirect_valid ? '0 : imem_rdata;
  assign wr_pc   = redirect_valid ? redirect_pc : inflight_pc;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx] <= wr_data;
      pc_q[wr_idx]   <= wr_pc;
      mis_q[wr_idx]  <= redirect_valid;
`ifdef PREFETCH_ILLEGAL_CHECK_EN
      ill_q[wr_idx]  <= !redirect_valid &&
                        ((wr_data[1:0] != 2'b11) || (wr_data == 32'h0) || (wr_data == 32'hFFFF_FFFF));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      // Clearing inflight here is the kill: the pending response is never pushed.
      inflight <= 1'b0;
      rd_ptr   <= '0;
      if (misal) begin
        wr_ptr <= PW'(1);
        count  <= CW'(1);
        state  <= HALT;
      end else begin
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= redirect_pc;
        state    <= RUN;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + AW'(4);
      end
    end
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: directed vector table plus randomized run against a queue model.
module tb_instr_prefetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_misaligned;
`ifdef PREFETCH_ILLEGAL_CHECK_EN
  logic        instr_illegal;
`endif

  instr_prefetch #(.AW(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
`ifdef PREFETCH_ILLEGAL_CHECK_EN
    .instr_illegal(instr_illegal),
`endif
    .instr_misaligned(instr_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
`ifdef PREFETCH_ILLEGAL_CHECK_EN
    if (a == 32'h10) return 32'h0000_000E;
`endif
    if (a[6:2] == 5'd7) return 32'hFFFF_FFFF;
    return 32'h13 + (a << 5);
  endfunction

  function automatic bit is_illegal(input logic [31:0] d);
    return (d[1:0] != 2'b11) || (d == 32'h0) || (d == 32'hFFFF_FFFF);
  endfunction

  // Instruction memory answers one cycle after the address is presented.
  always @(posedge clk) imem_rdata <= memword(imem_addr);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of delivered entries, next fetch PC, halt flag, one pending fetch.
  typedef struct { logic [31:0] d; logic [31:0] pc; logic mis; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  int          m_pend;
  logic [31:0] m_ppc;

  function automatic void model_reset();
    q.delete();
    m_pc = 32'h0; m_halt = 0; m_pend = 0; m_ppc = 0;
  endfunction

  typedef struct {
    bit rs; logic rdy; logic rv; logic [31:0] rpc;
    logic req; logic [31:0] addr; logic vld; logic [31:0] pc; logic [31:0] data; logic mis;
  } vec_t;

  function automatic vec_t mk(bit rs, logic rdy, logic rv, logic [31:0] rpc, logic req,
                              logic [31:0] addr, logic vld, logic [31:0] pc,
                              logic [31:0] data, logic mis);
    vec_t v;
    v.rs = rs; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.req = req; v.addr = addr;
    v.vld = vld; v.pc = pc; v.data = data; v.mis = mis;
    return v;
  endfunction

  task automatic cycle(input vec_t v, input bit tab);
    ent_t head;
    bit   e_vld, e_req;
    instr_ready = v.rdy; redirect_valid = v.rv; redirect_pc = v.rpc;
    @(negedge clk);
    e_vld = q.size() != 0;
    head  = e_vld ? q[0] : '{32'h0, 32'h0, 1'b0};
    e_req = !m_halt && !v.rv && (q.size() + m_pend < DEPTH);
    chk("valid", instr_valid, e_vld);
    chk("pc", instr_pc, head.pc);
    chk("data", instr_data, head.d);
    chk("mis", instr_misaligned, head.mis);
    chk("req", imem_req, e_req);
    if (e_req) chk("addr", imem_addr, m_pc);
`ifdef PREFETCH_ILLEGAL_CHECK_EN
    chk("illegal", instr_illegal, e_vld && !head.mis && is_illegal(head.d));
`endif
    if (tab) begin
      chk("t_valid", instr_valid, v.vld);
      chk("t_pc", instr_pc, v.pc);
      chk("t_data", instr_data, v.data);
      chk("t_mis", instr_misaligned, v.mis);
      chk("t_req", imem_req, v.req);
      if (v.req) chk("t_addr", imem_addr, v.addr);
    end
    if (v.rv) begin
      q.delete();
      m_pend = 0;
      if (v.rpc[1:0] == 2'b00) begin m_pc = v.rpc; m_halt = 0; end
      else begin q.push_back('{32'h0, v.rpc, 1'b1}); m_halt = 1; end
    end else begin
      if (e_vld && v.rdy) void'(q.pop_front());
      if (m_pend != 0) q.push_back('{memword(m_ppc), m_ppc, 1'b0});
      m_pend = e_req ? 1 : 0;
      if (e_req) begin m_ppc = m_pc; m_pc = m_pc + 32'd4; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0; redirect_pc = '0;
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  vec_t tv[$];

  initial begin
    logic [31:0] rpc;
    // Reset release, ready=1: back-to-back fetches, first head two cycles later.
    tv.push_back(mk(1, 1, 0, 0, 1, 'h0,  0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 'h4,  0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 'h8,  1, 'h0, 'h13, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 'hC,  1, 'h4, 'h93, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 'h10, 1, 'h8, 'h113, 0));
    // Decode stall: exactly DEPTH fetches, then resume right after the first pop.
    tv.push_back(mk(1, 0, 0, 0, 1, 'h0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 'h4, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 'h8, 1, 'h0, 'h13, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 'hC, 1, 'h0, 'h13, 0));
    for (int i = 0; i < 6; i++) tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 'h0, 'h13, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0,     1, 'h0, 'h13, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 'h10,  1, 'h4, 'h93, 0));
    // Redirect to 0x40 with 0x8 in flight and two buffered, then misaligned 0x42, then 0x80.
    tv.push_back(mk(1, 0, 0, 0,     1, 'h0,  0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,     1, 'h4,  0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,     1, 'h8,  1, 'h0, 'h13, 0));
    tv.push_back(mk(0, 0, 1, 'h40,  0, 0,    1, 'h0, 'h13, 0));
    tv.push_back(mk(0, 1, 0, 0,     1, 'h40, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0,     1, 'h44, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,     1, 'h48, 1, 'h40, 'h813, 0));
    tv.push_back(mk(0, 0, 1, 'h42,  0, 0,    1, 'h40, 'h813, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 0,    1, 'h42, 0, 1));
    tv.push_back(mk(0, 0, 0, 0,     0, 0,    1, 'h42, 0, 1));
    tv.push_back(mk(0, 1, 0, 0,     0, 0,    1, 'h42, 0, 1));
    tv.push_back(mk(0, 1, 0, 0,     0, 0,    0, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 'h80,  0, 0,    0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0,     1, 'h80, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0,     1, 'h84, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0,     1, 'h88, 1, 'h80, 'h1013, 0));

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rs) do_reset();
      cycle(tv[i], 1'b1);
    end

    // Reset asserted with the FIFO full: outputs clear at once, restart from RESET_PC.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_valid", instr_valid, 1'b0);
    chk("midrst_data", instr_data, 32'h0);
    chk("midrst_pc", instr_pc, 32'h0);
    chk("midrst_mis", instr_misaligned, 1'b0);
    chk("midrst_req", imem_req, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    instr_ready = 1'b1;
    #1;
    chk("midrst_first_req", imem_req, 1'b1);
    chk("midrst_first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) cycle(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // Randomized stalls and redirects (including back-to-back and misaligned).
    for (int i = 0; i < 3000; i++) begin
      rpc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      cycle(mk(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rpc,
               0, 0, 0, 0, 0, 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_prefetch.md
Name: instr_prefetch

Overview:
- Fetch-side stage directly upstream of the decode stage in cpu_top.
- Issues sequential word fetches to the instruction memory (u_imem) and buffers the returned words with their PCs in a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Handles redirects (branch/jump/exception vector) by flushing and refetching.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  AW  word-aligned fetch address.
- imem_rdata  in  32  fetch data; valid exactly one cycle after the request.
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  AW  new fetch PC.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts the head.
- instr_data  out  32  head instruction word.
- instr_pc  out  AW  head PC.
- instr_misaligned  out  1  head is a misaligned-fetch marker, not an instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; in-flight flag=0; state=RUN.
  - instr_valid=0, instr_data=0, instr_pc=0, instr_misaligned=0.
  - imem_req=0 while reset is asserted.
- States:
  - RUN: fetching.
  - HALT: stopped after a misaligned redirect.
- Request rule:
  - imem_req = (state==RUN) && !redirect_valid && (count + inflight < DEPTH).
  - imem_addr = fetch_pc.
  - On each issued request: fetch_pc += 4, wrapping modulo 2^AW; inflight<=1 for the next cycle.
- Response:
  - In the cycle after a surviving request, {imem_rdata, request PC, misaligned=0} is pushed.
  - Since count+inflight<DEPTH, the push never overflows.
- Pop:
  - Occurs when instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Outputs are driven from the FIFO head; zero when empty.
- Latency, no stalls:
  - Request in cycle N; push at edge N+1; instr_valid=1 in cycle N+2.
  - Throughput is one instruction per cycle in steady state.
- Redirect (redirect_valid=1, takes priority over everything):
  - FIFO is flushed at the edge; any pop in the same cycle is irrelevant.
  - The in-flight response arriving next cycle is discarded (kill flag).
  - No request is issued in the redirect cycle.
  - If redirect_pc[1:0]==0: fetch_pc<=redirect_pc, state RUN; first request issues the next cycle.
  - If redirect_pc[1:0]!=0: push one marker {data=0, pc=redirect_pc, misaligned=1}; state<=HALT; no further requests.
- HALT:
  - Exits only on a redirect.
  - The marker stays at the head until popped.
- Back-to-back redirects: the last one wins; each discards all earlier state.
- Reset mid-operation: all state cleared immediately; any in-flight response is ignored.
- Decode stall (instr_ready=0): FIFO fills to DEPTH, then imem_req=0. Requests resume in the cycle after the first pop frees a slot.

Optional Feature:
- Macro: PREFETCH_ILLEGAL_CHECK_EN.
- When defined:
  - Adds output instr_illegal (1 bit), stored per entry.
  - Set when pushed data has bits[1:0]!=2'b11, or equals 32'h0000_0000, or equals 32'hFFFF_FFFF.
  - Always 0 for misaligned markers; 0 at reset.
- When undefined: the port and per-entry storage are absent; all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0, instr_ready=1, imem words 0x13,0x93,0x113 -> requests at 0,4,8 on consecutive cycles; instr_valid rises 2 cycles after the first request; pairs (pc,data)=(0,0x13),(4,0x93),(8,0x113) on consecutive cycles.
- instr_ready=0 for 10 cycles -> exactly DEPTH=4 requests (0..0xC), then imem_req=0. Raising ready -> next request 0x10 issues the cycle after the first pop; no word lost or duplicated.
- redirect_valid with redirect_pc=0x40 while request 0x8 is in flight and 2 entries are buffered -> instr_valid=0 the next cycle; the 0x8 response is dropped; the next request is 0x40; first delivered pc=0x40.
- redirect_pc=0x42 -> single head entry pc=0x42, misaligned=1, data=0; no requests; after a pop and a redirect to 0x80, fetching resumes at 0x80.
- rst asserted mid-stream with FIFO full -> outputs are 0 immediately; after release the first request is RESET_PC.
- With PREFETCH_ILLEGAL_CHECK_EN defined, imem word at 0x10 = 32'h0000_000E -> that entry has instr_illegal=1; neighbouring 0x13 entries have 0.
